// File: rtl/alu_pkg.sv
// Shared encodings for the 8-bit ALU and its command sequencer.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_ROL = 3'b100;
  localparam logic [2:0] ALU_ROR = 3'b101;
  localparam logic [2:0] OP_LOAD = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_ROT  = 2'b10,
    ST_HOLD = 2'b11
  } seq_state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Command front end for the external 8-bit ALU: holds the accumulator, drives
// the ALU operands from registers and returns each result over a valid/ready stream.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [ALU_WIDTH-1:0] cmd_operand,
  output logic [ALU_WIDTH-1:0] alu_a,
  output logic [ALU_WIDTH-1:0] alu_b,
  output logic [2:0]           alu_sel,
  input  logic [ALU_WIDTH-1:0] alu_r,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ALU_WIDTH-1:0] res_data,
  output logic                 res_zero
);

  localparam int WIDTH = ALU_WIDTH;

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       rem_q, rem_d;
  logic             res_valid_q, res_valid_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             zero_q, zero_d;

  // Next-state, accumulator and operand latch logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          b_d = cmd_operand;
          case (cmd_op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR: begin
              sel_d   = cmd_op;
              state_d = ST_EXEC;
            end
            ALU_ROL, ALU_ROR: begin
              sel_d = cmd_op;
              if (cmd_operand[2:0] != 3'd0) begin
                rem_d   = cmd_operand[2:0];
                state_d = ST_ROT;
              end else begin
                state_d = ST_HOLD;
              end
            end
            OP_LOAD: begin
              sel_d   = ALU_ADD;
              acc_d   = cmd_operand;
              state_d = ST_HOLD;
            end
            default: begin
              sel_d   = ALU_ADD;
              state_d = ST_HOLD;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        acc_d   = alu_r;
        state_d = ST_HOLD;
      end
      ST_ROT: begin
        // Each pass applies one single-bit rotate from the ALU.
        acc_d = alu_r;
        rem_d = rem_q - 3'd1;
        if (rem_q == 3'd1) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_ROT;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered handshake flags derived from the upcoming state.
  always_comb begin
    res_valid_d = (state_d == ST_HOLD);
    cmd_ready_d = (state_d == ST_IDLE);
    zero_d      = (acc_d == {WIDTH{1'b0}});
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      sel_q       <= 3'b000;
      rem_q       <= 3'd0;
      res_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      zero_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      rem_q       <= rem_d;
      res_valid_q <= res_valid_d;
      cmd_ready_q <= cmd_ready_d;
      zero_q      <= zero_d;
    end
  end

  assign alu_a     = acc_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign res_data  = acc_q;
  assign res_valid = res_valid_q;
  assign cmd_ready = cmd_ready_q;
  assign res_zero  = zero_q;

endmodule
